// File: rtl/inst_issuer.sv
// ---------------------------------------------------------------------------
// inst_issuer
//   Initiator side of the call_modules instruction interface. Field-level
//   requests are packed into 32-bit ALU instruction words at push time and
//   buffered in a DEPTH-entry FIFO. Each word is driven on inst for exactly
//   ISSUE_GAP cycles. In hold cycle RESULT_LAT the matching alu_out is
//   captured and reported with a one-cycle res_valid pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   request present this cycle
//   in_ready   out  request accepted this cycle (push = in_valid & in_ready)
//   in_imm     in   1 = immediate form, 0 = register form
//   in_op      in   [2:0]  ALU opcode
//   in_rd      in   [4:0]  destination register
//   in_rs1     in   [4:0]  source register 1
//   in_rs2     in   [4:0]  source register 2 (register form only)
//   in_imm16   in   [15:0] immediate (immediate form only)
//   inst       out  [31:0] instruction word to call_modules, 0 = NOP
//   alu_out    in   [31:0] result from call_modules
//   res_valid  out  one-cycle pulse, res_data/res_rd valid
//   res_data   out  [31:0] captured alu_out
//   res_rd     out  [4:0]  rd of the instruction that produced res_data
//   busy       out  FIFO non-empty or an instruction in flight
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module inst_issuer #(
  parameter int DEPTH      = 8,
  parameter int ISSUE_GAP  = 3,
  parameter int RESULT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_imm,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [15:0] in_imm16,
  output logic [31:0] inst,
  input  logic [31:0] alu_out,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Issue FSM and registered outputs
  state_t        state_q,     state_d;
  logic [HW-1:0] hold_cnt_q,  hold_cnt_d;
  logic [31:0]   inst_q,      inst_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q,  res_data_d;
  logic [4:0]    res_rd_q,    res_rd_d;

  logic        fifo_empty;
  logic        last_hold;
  logic        pop;
  logic        push;
  logic [31:0] push_word;
  logic [31:0] head_word;

  assign fifo_empty = (count_q == '0);
  assign last_hold  = (hold_cnt_q == HW'(ISSUE_GAP - 1));
  assign head_word  = mem[rd_ptr_q];

  // A new word leaves the FIFO when nothing is held, or on the last hold cycle.
  assign pop = !fifo_empty && ((state_q == S_IDLE) || last_hold);

  // A pop frees a slot at the same edge, so a full FIFO still accepts a push
  // in a popping cycle and the count stays at DEPTH. Everything here is
  // derived from registered state only.
  assign in_ready = (count_q != CW'(DEPTH)) || pop;
  assign push     = in_valid && in_ready;

  assign push_word = in_imm ? {2'b01, 1'b1, in_op, in_rd, in_rs1, in_imm16}
                            : {2'b01, 1'b0, in_op, in_rd, in_rs1, in_rs2, 11'b0};

  // FIFO pointer / count next-state
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue FSM next-state
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    inst_d      = inst_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          inst_d     = head_word;
          hold_cnt_d = '0;
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        // Capture may coincide with the last hold cycle; rd comes from the
        // word still held on inst, so ordering does not matter.
        if (hold_cnt_q == HW'(RESULT_LAT)) begin
          res_valid_d = 1'b1;
          res_data_d  = alu_out;
          res_rd_d    = inst_q[25:21];
        end
        if (last_hold) begin
          hold_cnt_d = '0;
          if (pop) begin
            inst_d = head_word;
          end else begin
            inst_d  = '0;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        hold_cnt_d = '0;
        inst_d     = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      inst_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      inst_q      <= inst_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, as guarded by count_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

  assign inst      = inst_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign busy      = !fifo_empty || (state_q == S_HOLD);

endmodule
